pc_step_controller: RTL and testbench

//  Sequences the program_counter: drives its i_inc / i_load / i_addr from
//  run, halt, single-step and jump commands, plus a single address breakpoint.

---
 rtl/pc_step_controller.sv | 112 +++++++++++
 tb/tb_pc_step_controller.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_step_controller.sv
// Run/halt/step/jump sequencer for the program counter, with one address breakpoint.
// Every output is registered, so a command shows up as a strobe one cycle after it is sampled.
module pc_step_controller #(
  parameter int ADDR_WIDTH = 8,
  parameter int DIV_COUNT  = 16_000_000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_run,
  input  logic                  i_halt,
  input  logic                  i_step,
  input  logic                  i_jump,
  input  logic [ADDR_WIDTH-1:0] i_jump_addr,
  input  logic                  i_bp_en,
  input  logic [ADDR_WIDTH-1:0] i_bp_addr,
  input  logic [ADDR_WIDTH-1:0] i_pc_addr,
  output logic                  o_inc,
  output logic                  o_load,
  output logic [ADDR_WIDTH-1:0] o_load_addr,
  output logic                  o_running,
  output logic                  o_bp_hit
);

  localparam int DIV_W = (DIV_COUNT > 2) ? $clog2(DIV_COUNT) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_COUNT - 1);

  typedef enum logic {
    HALT = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic                  skip_q, skip_d;
  logic                  inc_q, inc_d;
  logic                  load_q, load_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  bp_q, bp_d;
  logic                  tick;

  assign tick = (state_q == RUN) && (div_q == DIV_LAST);

  always_comb begin
    state_d = state_q;
    div_d   = (state_q == RUN) ? (tick ? '0 : div_q + DIV_W'(1)) : '0;
    skip_d  = skip_q;
    inc_d   = 1'b0;
    load_d  = 1'b0;
    addr_d  = addr_q;
    bp_d    = bp_q;

    if (i_jump) begin
      load_d = 1'b1;
      addr_d = i_jump_addr;
      div_d  = '0;
      skip_d = 1'b1;
      bp_d   = 1'b0;
    end else if (i_halt) begin
      if (state_q == RUN) begin
        state_d = HALT;
        div_d   = '0;
      end
    end else if (state_q == HALT) begin
      // A step beats a simultaneous run, which is simply dropped.
      if (i_step) begin
        inc_d = 1'b1;
        bp_d  = 1'b0;
      end else if (i_run) begin
        state_d = RUN;
        div_d   = '0;
        skip_d  = 1'b1;
        bp_d    = 1'b0;
      end
    end else if (tick) begin
      // skip_q lets the first tick after a resume or jump leave the breakpoint address.
      if (i_bp_en && (i_pc_addr == i_bp_addr) && !skip_q) begin
        state_d = HALT;
        bp_d    = 1'b1;
      end else begin
        inc_d  = 1'b1;
        skip_d = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= HALT;
      div_q   <= '0;
      skip_q  <= 1'b0;
      inc_q   <= 1'b0;
      load_q  <= 1'b0;
      addr_q  <= '0;
      bp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      skip_q  <= skip_d;
      inc_q   <= inc_d;
      load_q  <= load_d;
      addr_q  <= addr_d;
      bp_q    <= bp_d;
    end
  end

  assign o_inc       = inc_q;
  assign o_load      = load_q;
  assign o_load_addr = addr_q;
  assign o_running   = (state_q == RUN);
  assign o_bp_hit    = bp_q;

endmodule

// File: tb/tb_pc_step_controller.sv
// Bench for pc_step_controller: a PC fixture follows the DUT strobes, and a
// tick-schedule reference model predicts every output cycle by cycle.
module tb_pc_step_controller;

  localparam int AW  = 8;
  localparam int DIV = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          runIn = 1'b0, haltIn = 1'b0, stepIn = 1'b0, jumpIn = 1'b0;
  logic [AW-1:0] jumpAddr = '0;
  logic          bpEn = 1'b0;
  logic [AW-1:0] bpAddr = '0;
  logic [AW-1:0] pc;
  logic          oInc, oLoad, oRunning, oBpHit;
  logic [AW-1:0] oLoadAddr;

  int nChecks = 0;
  int nFail   = 0;

  // Reference model: absolute edge index of the next RUN tick rather than a divider.
  int            cyc;
  int            nextTick;
  bit            mRun, mSkip, mBp, mInc, mLoad;
  logic [AW-1:0] mAddr, mPc;

  pc_step_controller #(.ADDR_WIDTH(AW), .DIV_COUNT(DIV)) dut (
    .i_clk(clk), .i_rst(rst), .i_run(runIn), .i_halt(haltIn), .i_step(stepIn),
    .i_jump(jumpIn), .i_jump_addr(jumpAddr), .i_bp_en(bpEn), .i_bp_addr(bpAddr),
    .i_pc_addr(pc), .o_inc(oInc), .o_load(oLoad), .o_load_addr(oLoadAddr),
    .o_running(oRunning), .o_bp_hit(oBpHit)
  );

  always #5 clk = ~clk;

  // The program counter as the board would wire it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        pc <= '0;
    else if (oLoad) pc <= oLoadAddr;
    else if (oInc)  pc <= pc + 8'd1;
  end

  function automatic logic [AW+3:0] dutOuts();
    return {oInc, oLoad, oLoadAddr, oRunning, oBpHit};
  endfunction

  function automatic logic [AW+3:0] modelOuts();
    return {mInc, mLoad, mAddr, mRun, mBp};
  endfunction

  task automatic modelReset();
    cyc = 0; nextTick = 0;
    mRun = 0; mSkip = 0; mBp = 0; mInc = 0; mLoad = 0;
    mAddr = '0; mPc = '0;
  endtask

  // Drive one cycle of commands, advance the model across the edge, settle 1 time unit past it.
  task automatic applyStimulus(input bit r, input bit h, input bit s, input bit j,
                               input logic [AW-1:0] ja);
    bit            nInc, nLoad;
    logic [AW-1:0] nPc;
    runIn = r; haltIn = h; stepIn = s; jumpIn = j; jumpAddr = ja;
    nInc = 0; nLoad = 0;
    nPc = mLoad ? mAddr : (mInc ? mPc + 8'd1 : mPc);
    if (j) begin
      nLoad = 1; mAddr = ja; nextTick = cyc + DIV; mSkip = 1; mBp = 0;
    end else if (h) begin
      mRun = 0;
    end else if (!mRun) begin
      if (s) begin
        nInc = 1; mBp = 0;
      end else if (r) begin
        mRun = 1; nextTick = cyc + DIV; mSkip = 1; mBp = 0;
      end
    end else if (cyc == nextTick) begin
      nextTick = cyc + DIV;
      if (bpEn && (mPc == bpAddr) && !mSkip) begin
        mRun = 0; mBp = 1;
      end else begin
        nInc = 1; mSkip = 0;
      end
    end
    @(posedge clk);
    #1;
    mInc = nInc; mLoad = nLoad; mPc = nPc;
    cyc++;
    runIn = 0; haltIn = 0; stepIn = 0; jumpIn = 0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    modelReset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    nChecks++;
    if (dutOuts() !== '0) begin
      nFail++;
      $display("[TB] FAIL reset_outs got=%h want=0", dutOuts());
    end
    for (int i = 0; i < 14; i++) begin
      applyStimulus(0, 0, (i == 10), 0, '0);
      nChecks++;
      if (dutOuts() !== modelOuts() || pc !== mPc) begin
        nFail++;
        $display("[TB] FAIL reset_step c%0d got=%h pc=%h want=%h pc=%h", i, dutOuts(), pc, modelOuts(), mPc);
      end
      if (i == 10) begin
        nChecks++;
        if (oInc !== 1'b1 || oRunning !== 1'b0) begin
          nFail++;
          $display("[TB] FAIL step_strobe got inc=%b run=%b want inc=1 run=0", oInc, oRunning);
        end
      end
    end
    nChecks++;
    if (pc !== 8'd1) begin
      nFail++;
      $display("[TB] FAIL step_pc got=%h want=01", pc);
    end
  endtask

  task automatic test_run_halt();
    int incs;
    doReset();
    incs = 0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus((i == 0), (i == 10), 0, 0, '0);
      incs += oInc;
      nChecks++;
      if (dutOuts() !== modelOuts() || pc !== mPc) begin
        nFail++;
        $display("[TB] FAIL run_halt c%0d got=%h pc=%h want=%h pc=%h", i, dutOuts(), pc, modelOuts(), mPc);
      end
    end
    nChecks++;
    if (incs != 2 || oRunning !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL run_halt_count got incs=%0d run=%b want incs=2 run=0", incs, oRunning);
    end
  endtask

  task automatic test_breakpoint();
    int budget;
    doReset();
    bpEn = 1'b1; bpAddr = 8'h03;
    applyStimulus(1, 0, 0, 0, '0);
    budget = 0;
    while (!mBp && budget < 40) begin
      applyStimulus(0, 0, 0, 0, '0);
      budget++;
      nChecks++;
      if (dutOuts() !== modelOuts() || pc !== mPc) begin
        nFail++;
        $display("[TB] FAIL bp_run c%0d got=%h pc=%h want=%h pc=%h", budget, dutOuts(), pc, modelOuts(), mPc);
      end
    end
    nChecks++;
    if (oBpHit !== 1'b1 || oRunning !== 1'b0 || pc !== 8'h03 || budget >= 40) begin
      nFail++;
      $display("[TB] FAIL bp_trap got hit=%b run=%b pc=%h want hit=1 run=0 pc=03", oBpHit, oRunning, pc);
    end
    applyStimulus(1, 0, 0, 0, '0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 0, 0, 0, '0);
      nChecks++;
      if (dutOuts() !== modelOuts() || pc !== mPc) begin
        nFail++;
        $display("[TB] FAIL bp_resume c%0d got=%h pc=%h want=%h pc=%h", i, dutOuts(), pc, modelOuts(), mPc);
      end
    end
    nChecks++;
    if (pc !== 8'h04 || oBpHit !== 1'b0 || oRunning !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL bp_no_retrap got pc=%h hit=%b run=%b want pc=04 hit=0 run=1", pc, oBpHit, oRunning);
    end
    bpEn = 1'b0;
  endtask

  task automatic test_jump();
    doReset();
    for (int i = 0; i <= 13; i++) begin
      applyStimulus((i == 0), 0, 0, (i == 8), 8'hA5);
      nChecks++;
      if (dutOuts() !== modelOuts() || pc !== mPc) begin
        nFail++;
        $display("[TB] FAIL jump c%0d got=%h pc=%h want=%h pc=%h", i, dutOuts(), pc, modelOuts(), mPc);
      end
      if (i == 8) begin
        nChecks++;
        if (oLoad !== 1'b1 || oInc !== 1'b0 || oLoadAddr !== 8'hA5) begin
          nFail++;
          $display("[TB] FAIL jump_on_tick got load=%b inc=%b addr=%h want 1 0 a5", oLoad, oInc, oLoadAddr);
        end
      end
    end
    nChecks++;
    if (pc !== 8'hA6) begin
      nFail++;
      $display("[TB] FAIL jump_pc got=%h want=a6", pc);
    end
  endtask

  task automatic test_back_to_back();
    doReset();
    applyStimulus(0, 0, 1, 1, 8'h3C);
    nChecks++;
    if (oLoad !== 1'b1 || oInc !== 1'b0 || oLoadAddr !== 8'h3C) begin
      nFail++;
      $display("[TB] FAIL jump_step got load=%b inc=%b addr=%h want 1 0 3c", oLoad, oInc, oLoadAddr);
    end
    applyStimulus(1, 0, 1, 0, '0);
    nChecks++;
    if (oInc !== 1'b1 || oLoad !== 1'b0 || oRunning !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL step_run got inc=%b load=%b run=%b want 1 0 0", oInc, oLoad, oRunning);
    end
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 0, 0, 0, '0);
      nChecks++;
      if (dutOuts() !== modelOuts() || pc !== mPc || oRunning !== 1'b0) begin
        nFail++;
        $display("[TB] FAIL step_run_idle c%0d got=%h pc=%h want=%h pc=%h", i, dutOuts(), pc, modelOuts(), mPc);
      end
    end
    nChecks++;
    if (pc !== 8'h3D) begin
      nFail++;
      $display("[TB] FAIL step_run_pc got=%h want=3d", pc);
    end
  endtask

  task automatic test_async_reset();
    int budget;
    doReset();
    applyStimulus(1, 0, 0, 0, '0);
    budget = 0;
    while (!mInc && budget < 10) begin
      applyStimulus(0, 0, 0, 0, '0);
      budget++;
    end
    nChecks++;
    if (oInc !== 1'b1 || budget >= 10) begin
      nFail++;
      $display("[TB] FAIL async_pre got inc=%b want=1", oInc);
    end
    #2 rst = 1'b1;
    #1;
    nChecks++;
    if (dutOuts() !== '0) begin
      nFail++;
      $display("[TB] FAIL async_rst_outs got=%h want=0", dutOuts());
    end
    modelReset();
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 0, 0, 0, '0);
      nChecks++;
      if (dutOuts() !== '0 || pc !== 8'h00) begin
        nFail++;
        $display("[TB] FAIL async_idle c%0d got=%h pc=%h want=0 pc=00", i, dutOuts(), pc);
      end
    end
  endtask

  task automatic test_random();
    bit r, h, s, j;
    doReset();
    for (int i = 0; i < 400; i++) begin
      if (i % 25 == 0) begin
        bpEn   = $urandom_range(0, 1);
        bpAddr = mPc + 8'($urandom_range(0, 3));
      end
      r = ($urandom_range(0, 9) == 0);
      h = ($urandom_range(0, 19) == 0);
      s = ($urandom_range(0, 9) == 0);
      j = ($urandom_range(0, 29) == 0);
      applyStimulus(r, h, s, j, 8'($urandom));
      nChecks++;
      if (dutOuts() !== modelOuts() || pc !== mPc) begin
        nFail++;
        $display("[TB] FAIL random c%0d got=%h pc=%h want=%h pc=%h", i, dutOuts(), pc, modelOuts(), mPc);
      end
    end
    bpEn = 1'b0;
  endtask

  initial begin
    modelReset();
    test_reset();
    test_run_halt();
    test_breakpoint();
    test_jump();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
